// File: rtl/sram16_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package sram16_pkg;
  typedef logic [1:0] fsm_t;

  localparam logic SIZ_BYTE = 1'b0;
  localparam logic SIZ_HALF = 1'b1;
  localparam int   CNT_W    = 4;
endpackage

// File: rtl/sram16_ctrl_if.sv
// 16-bit slave bus from the width bridge; master drives requests, slave acks.
interface sram16_ctrl_if;
  logic [63:0] s_adr_i;
  logic        s_cyc_i;
  logic        s_stb_i;
  logic        s_we_i;
  logic        s_siz_i;
  logic        s_signed_i;
  logic [15:0] s_dat_i;
  logic        s_ack_o;
  logic [15:0] s_dat_o;

  modport master (output s_adr_i, s_cyc_i, s_stb_i, s_we_i, s_siz_i, s_signed_i, s_dat_i,
                  input  s_ack_o, s_dat_o);
  modport slave  (input  s_adr_i, s_cyc_i, s_stb_i, s_we_i, s_siz_i, s_signed_i, s_dat_i,
                  output s_ack_o, s_dat_o);
endinterface

// File: rtl/sram16_lanes.sv
// Byte-lane decode plus write/read data steering; byte data is right-justified on the bus.
module sram16_lanes
  import sram16_pkg::*;
(
  input  logic        siz,
  input  logic        a0,
  input  logic [15:0] wdat,
  input  logic [15:0] rdat_sram,
  output logic        ub_en,
  output logic        lb_en,
  output logic [15:0] wdat_sram,
  output logic [15:0] rdat_bus
);
  always_comb begin
    ub_en     = (siz == SIZ_HALF) || a0;
    lb_en     = (siz == SIZ_HALF) || !a0;
    wdat_sram = (siz == SIZ_HALF) ? wdat : {wdat[7:0], wdat[7:0]};
    if (siz == SIZ_HALF) rdat_bus = rdat_sram;
    else if (a0)         rdat_bus = {8'h00, rdat_sram[15:8]};
    else                 rdat_bus = {8'h00, rdat_sram[7:0]};
  end
endmodule

// File: rtl/sram16_ctrl.sv
// Bus-to-async-SRAM controller with WAIT_STATES extra access cycles.
// Optional write protect input enabled by SRAM16_CTRL_WRITE_PROTECT_EN.
module sram16_ctrl
  import sram16_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef SRAM16_CTRL_WRITE_PROTECT_EN
  input  logic                  wp_i,
`endif
  sram16_ctrl_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] sram_adr_o,
  input  logic [15:0]           sram_dat_i,
  output logic [15:0]           sram_dat_o,
  output logic                  sram_dat_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_ub_n_o,
  output logic                  sram_lb_n_o
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  fsm_t             state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             r_we, r_siz, r_a0, r_abort;
  logic             n_we, n_siz, n_a0;
  logic             req, wp_hit, active;
  logic             ub_en, lb_en;
  logic [15:0]      wdat_sram, rdat_bus;
  logic             unused_bits;

  assign unused_bits = ^{bus.s_adr_i[63:ADDR_WIDTH+1], bus.s_signed_i};

`ifdef SRAM16_CTRL_WRITE_PROTECT_EN
  assign wp_hit = wp_i;
`else
  assign wp_hit = 1'b0;
`endif

  assign req = bus.s_cyc_i && bus.s_stb_i;

  // In IDLE the live request drives decode so strobes register on the accept edge.
  assign n_we  = (state == S_IDLE) ? bus.s_we_i     : r_we;
  assign n_siz = (state == S_IDLE) ? bus.s_siz_i    : r_siz;
  assign n_a0  = (state == S_IDLE) ? bus.s_adr_i[0] : r_a0;

  sram16_lanes u_lanes (
    .siz       (n_siz),
    .a0        (n_a0),
    .wdat      (bus.s_dat_i),
    .rdat_sram (sram_dat_i),
    .ub_en     (ub_en),
    .lb_en     (lb_en),
    .wdat_sram (wdat_sram),
    .rdat_bus  (rdat_bus)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (req) nxt = (wp_hit && bus.s_we_i) ? S_ACK : S_ACCESS;
      S_ACCESS: begin
        if (!bus.s_cyc_i)   nxt = r_we ? S_RECOVER : S_IDLE;
        else if (cnt == '0) nxt = r_we ? S_RECOVER : S_ACK;
      end
      S_RECOVER: nxt = r_abort ? S_IDLE : S_ACK;
      default:   nxt = S_IDLE;
    endcase
  end

  assign active = (nxt == S_ACCESS) || (nxt == S_RECOVER);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      r_we          <= 1'b0;
      r_siz         <= 1'b0;
      r_a0          <= 1'b0;
      r_abort       <= 1'b0;
      bus.s_ack_o   <= 1'b0;
      bus.s_dat_o   <= '0;
      sram_adr_o    <= '0;
      sram_dat_o    <= '0;
      sram_dat_oe_o <= 1'b0;
      sram_ce_n_o   <= 1'b1;
      sram_oe_n_o   <= 1'b1;
      sram_we_n_o   <= 1'b1;
      sram_ub_n_o   <= 1'b1;
      sram_lb_n_o   <= 1'b1;
    end else begin
      state       <= nxt;
      bus.s_ack_o <= (state == S_ACK);
      if (state == S_IDLE && req) begin
        r_we       <= bus.s_we_i;
        r_siz      <= bus.s_siz_i;
        r_a0       <= bus.s_adr_i[0];
        r_abort    <= 1'b0;
        cnt        <= CNT_W'(WAIT_STATES);
        sram_adr_o <= bus.s_adr_i[ADDR_WIDTH:1];
        sram_dat_o <= wdat_sram;
      end
      if (state == S_ACCESS) begin
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
        if (!bus.s_cyc_i) r_abort <= 1'b1;
        else if (cnt == '0 && !r_we) bus.s_dat_o <= rdat_bus;
      end
      // Strobes follow the next state so they are valid for the whole cycle spent there.
      sram_ce_n_o   <= !active;
      sram_oe_n_o   <= !((nxt == S_ACCESS) && !n_we);
      sram_we_n_o   <= !((nxt == S_ACCESS) && n_we);
      sram_dat_oe_o <= active && n_we;
      sram_ub_n_o   <= !(active && ub_en);
      sram_lb_n_o   <= !(active && lb_en);
    end
  end
endmodule

// File: tb/tb_sram16_ctrl.sv
// Randomized self-checking bench for sram16_ctrl against a byte-addressed memory model.
module tb_sram16_ctrl;
  import sram16_pkg::*;
  localparam int WS = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [AW-1:0] sram_adr_o;
  logic [15:0]   sram_dat_i, sram_dat_o;
  logic          sram_dat_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o;
`ifdef SRAM16_CTRL_WRITE_PROTECT_EN
  logic          wp = 1'b0;
`endif

  sram16_ctrl_if bus ();

  sram16_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .reset_i(reset_i),
`ifdef SRAM16_CTRL_WRITE_PROTECT_EN
    .wp_i(wp),
`endif
    .bus(bus.master),
    .sram_adr_o(sram_adr_o), .sram_dat_i(sram_dat_i), .sram_dat_o(sram_dat_o),
    .sram_dat_oe_o(sram_dat_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pin-level SRAM: 16 halfwords selected by sram_adr_o[3:0].
  logic [15:0] sram_mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;
  always @(posedge clk) begin
    if (pl_en) sram_mem[pl_idx] <= pl_val;
    else if (!sram_ce_n_o && !sram_we_n_o && sram_dat_oe_o) begin
      if (!sram_lb_n_o) sram_mem[sram_adr_o[3:0]][7:0]  <= sram_dat_o[7:0];
      if (!sram_ub_n_o) sram_mem[sram_adr_o[3:0]][15:8] <= sram_dat_o[15:8];
    end
  end
  assign sram_dat_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_adr_o[3:0]] : 16'hDEAD;

  // Reference model: byte-addressed view of the same 32 bytes.
  logic [7:0] ref_mem [32];

  function automatic logic [15:0] ref_read(input logic [63:0] a, input logic siz);
    int i = int'(a[4:0]);
    if (siz == SIZ_HALF) return {ref_mem[i | 1], ref_mem[i & 30]};
    return {8'h00, ref_mem[i]};
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic siz, input logic [15:0] wd);
    int i = int'(a[4:0]);
    if (siz == SIZ_HALF) begin
      ref_mem[i & 30] = wd[7:0];
      ref_mem[i | 1]  = wd[15:8];
    end else ref_mem[i] = wd[7:0];
  endtask

  task automatic preload(input int idx, input logic [15:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[3:0]; pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[2*idx]   = v[7:0];
    ref_mem[2*idx+1] = v[15:8];
  endtask

  // Bit k of each history = pin value observed after edge k (edge 0 = request edge).
  logic [39:0] ce_h, oe_h, we_h, doe_h;

  task automatic do_access(input logic we, input logic siz, input logic [63:0] adr,
                           input logic [15:0] wd, output logic [15:0] rd, output int lat,
                           output logic [AW-1:0] adr_seen, output logic [15:0] wdo_seen,
                           output logic [1:0] lanes_n_seen);
    lat = -1;
    ce_h = '1; oe_h = '1; we_h = '1; doe_h = '0;
    @(negedge clk);
    bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = we; bus.s_siz_i = siz;
    bus.s_adr_i = adr; bus.s_dat_i = wd; bus.s_signed_i = $urandom_range(0, 1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ce_h[k] = sram_ce_n_o; oe_h[k] = sram_oe_n_o; we_h[k] = sram_we_n_o; doe_h[k] = sram_dat_oe_o;
      if (k == 0) begin
        adr_seen = sram_adr_o; wdo_seen = sram_dat_o; lanes_n_seen = {sram_ub_n_o, sram_lb_n_o};
      end
      if (bus.s_ack_o) begin lat = k; break; end
    end
    rd = bus.s_dat_o;
    bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0; bus.s_we_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0; bus.s_we_i = 1'b0; bus.s_siz_i = 1'b0;
    bus.s_signed_i = 1'b0; bus.s_adr_i = '0; bus.s_dat_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.s_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", bus.s_ack_o); end
    checks++; if (bus.s_dat_o !== 16'h0000) begin failures++; $display("FAIL reset_dat got=%h want=0000", bus.s_dat_o); end
    checks++;
    if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o} !== 5'b11111) begin
      failures++; $display("FAIL reset_strobes got=%b want=11111",
        {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o});
    end
    checks++; if (sram_dat_oe_o !== 1'b0) begin failures++; $display("FAIL reset_dat_oe got=%b want=0", sram_dat_oe_o); end
    checks++; if (sram_adr_o !== '0) begin failures++; $display("FAIL reset_adr got=%h want=0", sram_adr_o); end
    for (int i = 0; i < 16; i++) preload(i, 16'($urandom));
    reset_i = 1'b0;
  endtask

  task automatic test_byte_read();
    logic [15:0] rd, wdo; int lat; logic [AW-1:0] a; logic [1:0] ln;
    preload(8, 16'hAA55);
    do_access(1'b0, SIZ_BYTE, 64'h4444_3333_2222_1111, 16'h0, rd, lat, a, wdo, ln);
    checks++; if (a !== 20'h10888) begin failures++; $display("FAIL bread_adr got=%h want=10888", a); end
    checks++; if (ln !== 2'b01) begin failures++; $display("FAIL bread_lanes ub_n,lb_n got=%b want=01", ln); end
    checks++; if (oe_h[3:0] !== 4'b1000) begin failures++; $display("FAIL bread_oe got=%b want=1000", oe_h[3:0]); end
    checks++; if (lat != WS + 2) begin failures++; $display("FAIL bread_lat got=%0d want=%0d", lat, WS + 2); end
    checks++; if (rd !== 16'h00AA) begin failures++; $display("FAIL bread_dat got=%h want=00AA", rd); end
  endtask

  task automatic test_byte_write();
    logic [15:0] rd, wdo; int lat; logic [AW-1:0] a; logic [1:0] ln;
    do_access(1'b1, SIZ_BYTE, 64'h4444_3333_2222_1110, 16'hBBDD, rd, lat, a, wdo, ln);
    ref_write(64'h4444_3333_2222_1110, SIZ_BYTE, 16'hBBDD);
    checks++; if (wdo !== 16'hDDDD) begin failures++; $display("FAIL bwrite_dat got=%h want=DDDD", wdo); end
    checks++; if (ln !== 2'b10) begin failures++; $display("FAIL bwrite_lanes ub_n,lb_n got=%b want=10", ln); end
    checks++; if (we_h[3:0] !== 4'b1000) begin failures++; $display("FAIL bwrite_we got=%b want=1000", we_h[3:0]); end
    checks++;
    if ({ce_h[3], doe_h[3]} !== 2'b01) begin
      failures++; $display("FAIL bwrite_recover ce_n,dat_oe got=%b want=01", {ce_h[3], doe_h[3]});
    end
    checks++; if (lat != WS + 3) begin failures++; $display("FAIL bwrite_lat got=%0d want=%0d", lat, WS + 3); end
    checks++;
    if (sram_mem[8] !== {ref_mem[17], ref_mem[16]}) begin
      failures++; $display("FAIL bwrite_mem got=%h want=%h", sram_mem[8], {ref_mem[17], ref_mem[16]});
    end
  endtask

  task automatic test_half_read();
    logic [15:0] rd, wdo; int lat; logic [AW-1:0] a; logic [1:0] ln;
    preload(0, 16'h1234);
    for (int j = 0; j < 2; j++) begin
      do_access(1'b0, SIZ_HALF, 64'h2000 + 64'(j), 16'h0, rd, lat, a, wdo, ln);
      checks++; if (a !== 20'h01000) begin failures++; $display("FAIL hread_adr%0d got=%h want=01000", j, a); end
      checks++; if (ln !== 2'b00) begin failures++; $display("FAIL hread_lanes%0d got=%b want=00", j, ln); end
      checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL hread_dat%0d got=%h want=1234", j, rd); end
    end
  endtask

  task automatic test_abort();
    logic [15:0] rd, wdo; int lat; logic [AW-1:0] a; logic [1:0] ln; int acks = 0;
    @(negedge clk);
    bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = 1'b0; bus.s_siz_i = SIZ_HALF; bus.s_adr_i = 64'h2000;
    @(negedge clk);
    @(negedge clk);
    bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({sram_ce_n_o, sram_oe_n_o} !== 2'b11) begin
      failures++; $display("FAIL abort_strobes ce_n,oe_n got=%b want=11", {sram_ce_n_o, sram_oe_n_o});
    end
    for (int k = 0; k < 6; k++) begin
      if (bus.s_ack_o) acks++;
      @(negedge clk);
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL abort_ack got=%0d want=0", acks); end
    do_access(1'b0, SIZ_HALF, 64'h2000, 16'h0, rd, lat, a, wdo, ln);
    checks++; if (lat != WS + 2) begin failures++; $display("FAIL abort_next_lat got=%0d want=%0d", lat, WS + 2); end
    checks++;
    if (rd !== ref_read(64'h2000, SIZ_HALF)) begin
      failures++; $display("FAIL abort_next_dat got=%h want=%h", rd, ref_read(64'h2000, SIZ_HALF));
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd, wdo, wd; int lat; logic [AW-1:0] a; logic [1:0] ln;
    wd = 16'($urandom);
    @(negedge clk);
    bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = 1'b1; bus.s_siz_i = SIZ_HALF;
    bus.s_adr_i = 64'h4; bus.s_dat_i = wd;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_we_n_o, sram_ce_n_o, sram_dat_oe_o, bus.s_ack_o} !== 4'b1100) begin
      failures++; $display("FAIL midreset we_n,ce_n,dat_oe,ack got=%b want=1100",
        {sram_we_n_o, sram_ce_n_o, sram_dat_oe_o, bus.s_ack_o});
    end
    reset_i = 1'b0; bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0; bus.s_we_i = 1'b0;
    ref_write(64'h4, SIZ_HALF, wd);
    do_access(1'b0, SIZ_HALF, 64'h4, 16'h0, rd, lat, a, wdo, ln);
    checks++; if (lat != WS + 2) begin failures++; $display("FAIL midreset_lat got=%0d want=%0d", lat, WS + 2); end
    checks++; if (rd !== wd) begin failures++; $display("FAIL midreset_dat got=%h want=%h", rd, wd); end
  endtask

  task automatic test_random();
    logic [15:0] rd, wdo, wd; int lat; logic [AW-1:0] a; logic [1:0] ln;
    logic [63:0] adr; logic we, siz;
    for (int n = 0; n < 40; n++) begin
      adr = {32'($urandom), 32'($urandom)};
      we = 1'($urandom_range(0, 1)); siz = 1'($urandom_range(0, 1)); wd = 16'($urandom);
      do_access(we, siz, adr, wd, rd, lat, a, wdo, ln);
      checks++; if (a !== adr[AW:1]) begin failures++; $display("FAIL rnd_adr%0d got=%h want=%h", n, a, adr[AW:1]); end
      if (we) begin
        ref_write(adr, siz, wd);
        checks++; if (lat != WS + 3) begin failures++; $display("FAIL rnd_wlat%0d got=%0d want=%0d", n, lat, WS + 3); end
      end else begin
        checks++; if (lat != WS + 2) begin failures++; $display("FAIL rnd_rlat%0d got=%0d want=%0d", n, lat, WS + 2); end
        checks++;
        if (rd !== ref_read(adr, siz)) begin
          failures++; $display("FAIL rnd_rdat%0d got=%h want=%h", n, rd, ref_read(adr, siz));
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sram_mem[i] !== {ref_mem[2*i+1], ref_mem[2*i]}) begin
        failures++; $display("FAIL rnd_mem%0d got=%h want=%h", i, sram_mem[i], {ref_mem[2*i+1], ref_mem[2*i]});
      end
    end
  endtask

`ifdef SRAM16_CTRL_WRITE_PROTECT_EN
  task automatic test_write_protect();
    logic [15:0] rd, wdo; int lat; logic [AW-1:0] a; logic [1:0] ln;
    wp = 1'b1;
    do_access(1'b1, SIZ_HALF, 64'hA, ~ref_read(64'hA, SIZ_HALF), rd, lat, a, wdo, ln);
    wp = 1'b0;
    checks++; if (lat != 1) begin failures++; $display("FAIL wp_lat got=%0d want=1", lat); end
    checks++;
    if ({ce_h[1:0], we_h[1:0]} !== 4'b1111) begin
      failures++; $display("FAIL wp_strobes got=%b want=1111", {ce_h[1:0], we_h[1:0]});
    end
    checks++;
    if (sram_mem[5] !== {ref_mem[11], ref_mem[10]}) begin
      failures++; $display("FAIL wp_mem got=%h want=%h", sram_mem[5], {ref_mem[11], ref_mem[10]});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_byte_read();
    test_byte_write();
    test_half_read();
    test_abort();
    test_reset_mid();
`ifdef SRAM16_CTRL_WRITE_PROTECT_EN
    test_write_protect();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram16_ctrl.md
Name: sram16_ctrl

Overview:
- Slave-side target for the 16-bit bus from the 64→16-bit width bridge.
- Turns each byte or halfword bus cycle into one asynchronous 16-bit SRAM access, with a programmable number of wait states.
- Handles byte-lane steering: byte data is right-justified on both s_dat_i and s_dat_o. Sign extension is done upstream; s_signed_i is accepted but ignored.

Parameters:
- ADDR_WIDTH, 20, SRAM halfword-address width; sram_adr_o = s_adr_i[ADDR_WIDTH:1].
- WAIT_STATES, 2, extra ACCESS cycles beyond the first. Legal range 0..15.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- s_adr_i  in  64  byte address.
- s_cyc_i  in  1  bus cycle in progress.
- s_stb_i  in  1  transfer request.
- s_we_i  in  1  1=write, 0=read.
- s_siz_i  in  1  0=byte, 1=halfword.
- s_signed_i  in  1  ignored.
- s_dat_i  in  16  write data; byte writes use [7:0].
- s_ack_o  out  1  one-cycle transfer acknowledge.
- s_dat_o  out  16  read data; byte reads zero-extended in [15:8].
- sram_adr_o  out  ADDR_WIDTH  SRAM halfword address.
- sram_dat_i  in  16  SRAM read data.
- sram_dat_o  out  16  SRAM write data.
- sram_dat_oe_o  out  1  data-bus drive enable.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low chip, output and write enables.
- sram_ub_n_o, sram_lb_n_o  out  1 each  active-low byte-lane enables; ub=[15:8], lb=[7:0].

Behaviour:
- All outputs registered.
- Reset values: s_ack_o=0, s_dat_o=0, sram_adr_o=0, sram_dat_o=0, sram_dat_oe_o=0, all *_n_o=1. FSM goes to IDLE.
- Reset takes priority over all other inputs, including in mid-access.
- FSM states: IDLE, ACCESS, RECOVER, ACK.
- IDLE:
  - Leaves only when s_cyc_i & s_stb_i are both sampled high.
  - On leaving, latches address, write data, we, siz and lanes, loads the wait counter with WAIT_STATES, and enters ACCESS.
- Lanes:
  - siz=1: both lanes enabled; address bit 0 is ignored (aligned down).
  - siz=0 with adr[0]=0: lb only.
  - siz=0 with adr[0]=1: ub only.
- Byte write data: sram_dat_o = {s_dat_i[7:0], s_dat_i[7:0]}.
- ACCESS:
  - Lasts WAIT_STATES+1 cycles. ce_n=0 throughout.
  - Read: oe_n=0. Write: we_n=0 and dat_oe=1.
  - The counter decrements each cycle. Exit when it reaches 0.
  - Read exit: capture sram_dat_i with lane steering into s_dat_o, then go to ACK. Byte reads return {8'h00, selected byte}.
  - Write exit: go to RECOVER.
- RECOVER (writes only):
  - One cycle with we_n=1 while ce_n, lanes, dat_oe and data are still held (data hold time).
  - Then go to ACK.
- ACK:
  - s_ack_o=1 for exactly one cycle; all SRAM strobes inactive.
  - Next state is IDLE. If stb is still high, a new access is sampled in IDLE.
- Latency, counted from the request edge (edge 0):
  - Read ack is visible after edge WAIT_STATES+2.
  - Write ack is visible after edge WAIT_STATES+3.
- s_dat_o holds its last captured read value until the next read capture.
- Abort when s_cyc_i is sampled low during ACCESS:
  - Read: go straight to IDLE with strobes deasserted, no ack.
  - Write: go to RECOVER then IDLE, no ack, so WE never overlaps the address change.
- s_stb_i changes after the request is latched are ignored; only s_cyc_i aborts.

Optional Feature:
- Macro: SRAM16_CTRL_WRITE_PROTECT_EN.
- When defined:
  - Adds input port wp_i.
  - A write request sampled while wp_i=1 goes IDLE→ACK directly, ack after edge 1.
  - ce_n and we_n are never asserted for that write, and SRAM contents are unchanged.
  - Reads are unaffected.
- When undefined: no wp_i port, and all writes proceed normally.

Decomposition:
- Package sram16_pkg holds:
  - FSM state typedef (2-bit).
  - SIZ_BYTE=1'b0 and SIZ_HALF=1'b1 constants.
  - Wait-counter width constant (4).
- Sub-module sram16_lanes (combinational) holds the lane/strobe decode and read/write data steering.
- The top module holds the FSM and registers.

Test Plan (WAIT_STATES=2, ADDR_WIDTH=20):
- Reset: assert reset_i 2 cycles → s_ack_o=0, s_dat_o=0000, all *_n_o=1, dat_oe=0.
- Byte read at s_adr_i=64'h4444_3333_2222_1111, sram_dat_i=16'hAA55 → sram_adr_o=20'h10888, ub_n=0, lb_n=1, oe_n=0 for 3 cycles, ack after edge 4, s_dat_o=16'h00AA.
- Byte write at 64'h…2222_1110, s_dat_i=16'hBBDD → sram_dat_o=16'hDDDD, lb_n=0, ub_n=1, we_n=0 for 3 cycles, RECOVER 1 cycle with we_n=1, ack after edge 5.
- Halfword read at 64'h2000, sram_dat_i=16'h1234 → sram_adr_o=20'h01000, both lanes enabled, s_dat_o=16'h1234; repeat at 64'h2001 → identical result.
- Read with s_cyc_i dropped during the 2nd ACCESS cycle → no ack, ce_n=1 next cycle; a following halfword read completes normally.
- Reset asserted during write ACCESS → next edge we_n=1, ce_n=1, dat_oe=0, FSM in IDLE, no ack.
- With SRAM16_CTRL_WRITE_PROTECT_EN defined and wp_i=1: write → ack after edge 1, we_n and ce_n stay 1.
